// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Purpose  : Oversampled I2C target exposing a byte-wide register file.
//            It supports a register pointer, burst writes and reads with
//            auto-increment and wrap, repeated START, and STOP detection.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDRESS   7-bit target address
//   NUM_REGS  register count (2..256); PTR_W = $clog2(NUM_REGS)
// Ports:
//   clk        system clock (>= 16x SCL)
//   rst_n      synchronous active-low reset
//   scl_i      raw SCL pin level (asynchronous)
//   sda_i      raw SDA pin level (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   regs_flat  register contents, reg k at [8k+7:8k]
//   wr_strobe  one-cycle pulse per accepted write byte
//   wr_index   register written (valid with wr_strobe)
//   wr_data    byte written (valid with wr_strobe)
//   busy       high while addressed, from address match until STOP/exit
//   state_out  current FSM state code
// Build option:
//   I2C_SLAVE_GLITCH_FILTER_EN  adds a 3-sample majority filter per input
//                              (input latency 5 clk instead of 3)
// ============================================================================
module i2c_slave_regfile #(
    parameter logic [6:0] ADDRESS  = 7'h2A,
    parameter int         NUM_REGS = 8,
    localparam int        PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic [3:0]            state_out
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } state_t;

    localparam logic [8:0] NREGS_9 = 9'(NUM_REGS);

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronisers, optional majority filter,
    // then a one-cycle-delayed copy for edge detection.
    // ------------------------------------------------------------------
    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_lvl, sda_lvl;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // Majority of the current and two previous synchronised samples: a
    // pulse lasting one clk never holds two of the three votes at once.
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_filt_d = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1])
                   | (scl_hist_q[0] & scl_hist_q[1]);
        sda_filt_d = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1])
                   | (sda_hist_q[0] & sda_hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_lvl = scl_filt_q;
    assign sda_lvl = sda_filt_q;
`else
    assign scl_lvl = scl_sync_q[1];
    assign sda_lvl = sda_sync_q[1];
`endif

    always_comb begin
        scl_prev_d = scl_lvl;
        sda_prev_d = sda_lvl;
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_lvl & ~scl_prev_q;
    assign scl_fall  = ~scl_lvl &  scl_prev_q;
    assign start_det =  scl_lvl & ~sda_lvl &  sda_prev_q;
    assign stop_det  =  scl_lvl &  sda_lvl & ~sda_prev_q;

    // ------------------------------------------------------------------
    // Protocol FSM and register file
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REGS*8-1:0] regs_q, regs_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]      wr_index_q, wr_index_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;

    logic [7:0]       rx_byte, cur_reg;
    logic [PTR_W-1:0] ptr_inc;
    logic             last_bit;

    assign rx_byte  = {shift_q[6:0], sda_lvl};
    assign cur_reg  = regs_q[{ptr_q, 3'b000} +: 8];
    assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    assign last_bit = (bit_cnt_q == 4'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;

        if (start_det) begin
            // Repeated START keeps the pointer so a read can follow a
            // pointer-only write.
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            // Receive states share the shift-in on SCL rise.
            if (scl_rise && (state_q == ST_ADDR || state_q == ST_PTR || state_q == ST_WDATA)) begin
                shift_d   = rx_byte;
                bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            end

            unique case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise && last_bit) begin
                        if (rx_byte[7:1] == ADDRESS) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise && last_bit) begin
                        if ({1'b0, rx_byte} < NREGS_9) begin
                            ptr_d   = rx_byte[PTR_W-1:0];
                            state_d = ST_PTR_ACK;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise && last_bit) begin
                        regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
                        wr_strobe_d = 1'b1;
                        wr_index_d  = ptr_q;
                        wr_data_d   = rx_byte;
                        state_d     = ST_WDATA_ACK;
                    end
                end
                // ACK states: first SCL fall pulls SDA low, second releases
                // it and moves on. bit_cnt bit 0 marks the ACK as driven.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_WDATA_ACK) begin
                                ptr_d   = ptr_inc;
                                state_d = ST_WDATA;
                            end else if (state_q == ST_PTR_ACK || !rw_q) begin
                                state_d = (state_q == ST_PTR_ACK) ? ST_WDATA : ST_PTR;
                            end else begin
                                // Read: present the MSB in the same fall.
                                sda_oe_d = ~cur_reg[7];
                                shift_d  = {cur_reg[6:0], 1'b0};
                                state_d  = ST_RDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    // bit_cnt = 1 records a controller ACK awaiting the fall
                    // at which the next byte starts.
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        if (!sda_lvl) begin
                            ptr_d     = ptr_inc;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d  = ST_IDLE;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        sda_oe_d  = ~cur_reg[7];
                        shift_d   = {cur_reg[6:0], 1'b0};
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            regs_q      <= '0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Purpose  : Self-checking bench for i2c_slave_regfile. An I2C controller
//            model drives the bus; a transaction-level register model
//            predicts ACKs, read data and write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

    localparam int         NREG = 8;
    localparam int         Q    = 10;      // clk cycles per quarter SCL period
    localparam logic [6:0] ADDR = 7'h2A;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    logic sda_line;

    logic              sda_oe;
    logic [NREG*8-1:0] regs_flat;
    logic              wr_strobe;
    logic [2:0]        wr_index;
    logic [7:0]        wr_data;
    logic              busy;
    logic [3:0]        state_out;

    assign sda_line = sda_drv & ~sda_oe;   // open-drain wired-AND
    always #5 clk = ~clk;

    i2c_slave_regfile #(.ADDRESS(ADDR), .NUM_REGS(NREG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_drv),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .busy     (busy),
        .state_out(state_out)
    );

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         n_strobe = 0;
    logic [7:0] m_regs [NREG];
    int         m_ptr;
    logic       m_live;
    int         exp_idx [$];
    logic [7:0] exp_dat [$];
    logic       oe_seen = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // ---------------- per-cycle compare process ----------------
    logic [63:0] shadow    = '0;
    logic [63:0] last_flat = '0;
    logic        prev_oe   = 1'b0;
    logic        prev_rst  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            shadow = '0;
            exp_idx.delete();
            exp_dat.delete();
        end else begin
            if (wr_strobe) begin
                n_strobe++;
                if (exp_idx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wr_strobe: got index %0d data 0x%0h, expected no strobe",
                             wr_index, wr_data);
                end else begin
                    int         i;
                    logic [7:0] d;
                    i = exp_idx.pop_front();
                    d = exp_dat.pop_front();
                    check("wr_index", 64'(wr_index), 64'(i));
                    check("wr_data", 64'(wr_data), 64'(d));
                    shadow[i*8 +: 8] = d;
                end
            end
            if (wr_strobe || regs_flat != last_flat)
                check("regs_flat", regs_flat, shadow);
            if (prev_rst && sda_oe != prev_oe)
                check("sda_oe_change_scl_low", 64'(scl_drv), 64'(0));
            if (sda_oe) oe_seen = 1'b1;
        end
        last_flat = regs_flat;
        prev_oe   = sda_oe;
        prev_rst  = rst_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- bus-level controller ----------------
    task automatic quarter();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; quarter();
        scl_drv = 1'b1; quarter();
        sda_drv = 1'b0; quarter();
        scl_drv = 1'b0; quarter();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; quarter();
        scl_drv = 1'b1; quarter();
        sda_drv = 1'b1; quarter();
    endtask

    task automatic put_bit(input logic b);
        sda_drv = b;    quarter();
        scl_drv = 1'b1; quarter(); quarter();
        scl_drv = 1'b0; quarter();
    endtask

    task automatic get_bit(output logic b);
        sda_drv = 1'b1; quarter();
        scl_drv = 1'b1; quarter();
        b = sda_line;   quarter();
        scl_drv = 1'b0; quarter();
    endtask

    task automatic put_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    // ---------------- transaction-level model ----------------
    task automatic t_addr(input logic [6:0] a, input logic rw);
        logic acked;
        m_live = (a == ADDR);
        put_byte({a, rw}, acked);
        check("addr_ack", 64'(acked), 64'(m_live));
    endtask

    task automatic t_ptr(input logic [7:0] p);
        logic acked, ok;
        ok = m_live && (int'(p) < NREG);
        put_byte(p, acked);
        check("ptr_ack", 64'(acked), 64'(ok));
        if (ok) m_ptr = int'(p);
        else    m_live = 1'b0;
    endtask

    task automatic t_wdata(input logic [7:0] d);
        logic acked, ok;
        ok = m_live;
        if (ok) begin
            exp_idx.push_back(m_ptr);
            exp_dat.push_back(d);
            m_regs[m_ptr] = d;
            m_ptr = (m_ptr + 1) % NREG;
        end
        put_byte(d, acked);
        check("wdata_ack", 64'(acked), 64'(ok));
    endtask

    task automatic t_rdata(input logic ack, output logic [7:0] got);
        logic [7:0] want;
        want = m_regs[m_ptr];
        get_byte(got, ack);
        check("rdata", 64'(got), 64'(want));
        if (ack) m_ptr = (m_ptr + 1) % NREG;
        else     m_live = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr  = 0;
        m_live = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] got;
        int         s0;
        logic       seen;
        logic       exp_seen;

        model_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe",    64'(sda_oe),    64'(0));
        check("rst_wr_strobe", 64'(wr_strobe), 64'(0));
        check("rst_wr_index",  64'(wr_index),  64'(0));
        check("rst_wr_data",   64'(wr_data),   64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_state",     64'(state_out), 64'(0));
        check("rst_regs",      regs_flat,      64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        quarter();

        // Write burst: ptr 2, A5, 3C
        bus_start();
        t_addr(ADDR, 1'b0);
        check("busy_after_match", 64'(busy), 64'(1));
        check("state_ptr", 64'(state_out), 64'(3));
        t_ptr(8'h02);
        t_wdata(8'hA5);
        t_wdata(8'h3C);
        bus_stop();
        check("busy_after_stop", 64'(busy), 64'(0));
        check("lit_reg2", 64'(regs_flat[23:16]), 64'(8'hA5));
        check("lit_reg3", 64'(regs_flat[31:24]), 64'(8'h3C));
        check("lit_strobes", 64'(n_strobe), 64'(2));

        // Read with repeated START from ptr 3
        bus_start();
        t_addr(ADDR, 1'b0);
        t_ptr(8'h03);
        bus_start();
        t_addr(ADDR, 1'b1);
        t_rdata(1'b1, got);
        check("lit_read0", 64'(got), 64'(8'h3C));
        t_rdata(1'b0, got);
        check("lit_read1", 64'(got), 64'(8'h00));
        quarter();
        check("oe_after_nack", 64'(sda_oe), 64'(0));
        check("state_after_nack", 64'(state_out), 64'(0));
        bus_stop();

        // Wrap-around from ptr 7
        bus_start();
        t_addr(ADDR, 1'b0);
        t_ptr(8'h07);
        t_wdata(8'h11);
        t_wdata(8'h22);
        t_wdata(8'h33);
        bus_stop();
        check("lit_reg7", 64'(regs_flat[63:56]), 64'(8'h11));
        check("lit_reg0", 64'(regs_flat[7:0]),   64'(8'h22));

        // Address mismatch: no ACK, no drive, no strobe
        oe_seen = 1'b0;
        s0 = n_strobe;
        bus_start();
        t_addr(7'h2B, 1'b0);
        t_wdata(8'h77);
        bus_stop();
        check("mismatch_no_oe", 64'(oe_seen), 64'(0));
        check("mismatch_no_strobe", 64'(n_strobe), 64'(s0));
        check("mismatch_busy", 64'(busy), 64'(0));

        // Out-of-range pointer: NACK, pointer keeps 2
        bus_start();
        t_addr(ADDR, 1'b0);
        t_ptr(8'h08);
        t_wdata(8'h99);
        bus_stop();
        bus_start();
        t_addr(ADDR, 1'b1);
        t_rdata(1'b0, got);
        check("lit_ptr_kept", 64'(got), 64'(8'hA5));
        bus_stop();

        // Reset while the target drives a 0 read bit (0x3C MSB)
        bus_start();
        t_addr(ADDR, 1'b0);
        t_ptr(8'h03);
        bus_start();
        t_addr(ADDR, 1'b1);
        sda_drv = 1'b1; quarter();
        scl_drv = 1'b1; quarter();
        check("read_bit0_driven", 64'(sda_oe), 64'(1));
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("midrst_sda_oe", 64'(sda_oe),    64'(0));
        check("midrst_regs",   regs_flat,      64'(0));
        check("midrst_state",  64'(state_out), 64'(0));
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        quarter();

        // 1-clk SDA low pulse with SCL high
        seen = 1'b0;
        @(negedge clk) sda_drv = 1'b0;
        @(negedge clk) sda_drv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state_out == 4'd1) seen = 1'b1;
        end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        exp_seen = 1'b0;
`else
        exp_seen = 1'b1;
`endif
        check("glitch_start", 64'(seen), 64'(exp_seen));
        quarter();

        // Write and read back after reset
        bus_start();
        t_addr(ADDR, 1'b0);
        t_ptr(8'h00);
        t_wdata(8'h5A);
        bus_stop();
        bus_start();
        t_addr(ADDR, 1'b0);
        t_ptr(8'h00);
        bus_start();
        t_addr(ADDR, 1'b1);
        t_rdata(1'b0, got);
        check("lit_readback", 64'(got), 64'(8'h5A));
        bus_stop();

        check("pending_writes", 64'(exp_idx.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
